// File: rtl/stage_sink.sv
// Sink stage: a small FIFO drained into a registered output, with a
// sequence checker (each word should be the previous word plus one) and a running sum.
module stage_sink #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_stall,
    input  logic          i_internal_stall,
    input  logic          i_flush,
    output logic [DW-1:0] o_data,
    output logic          o_data_valid,
    output logic          o_seq_err,
    output logic [7:0]    o_err_count,
    output logic [31:0]   o_sum
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        UNARMED = 1'b0,
        TRACK   = 1'b1
    } chk_state_t;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] occ_reg, occ_next;

    logic [DW-1:0] data_reg;
    logic          data_valid_reg;
    logic          seq_err_reg;
    logic [7:0]    err_count_reg;
    logic [31:0]   sum_reg;

    chk_state_t    state_reg, state_next;
    logic [DW-1:0] expected_reg, expected_next;

    logic          full;
    logic          push;
    logic          pop;
    logic          mismatch;
    logic [DW-1:0] pop_word;

    // Full is decoded from the registered occupancy only, so a push is refused
    // while full even if the same cycle also pops.
    assign full     = (occ_reg == CW'(DEPTH));
    assign push     = i_valid && !full && !i_flush;
    assign pop      = (occ_reg != '0) && !i_internal_stall && !i_flush;
    assign pop_word = mem[rd_ptr_reg];

    // Storage carries no reset; only entries below the occupancy are ever read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= i_data;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        occ_next    = occ_reg;
        if (i_flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            occ_next    = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                occ_next = occ_reg + 1'b1;
            end else if (pop && !push) begin
                occ_next = occ_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            occ_reg    <= occ_next;
        end
    end

    // Checker: the first pop after reset or flush only arms the expectation.
    always_comb begin
        state_next    = state_reg;
        expected_next = expected_reg;
        mismatch      = 1'b0;
        if (pop) begin
            state_next    = TRACK;
            expected_next = pop_word + DW'(1);
            if ((state_reg == TRACK) && (pop_word != expected_reg)) begin
                mismatch = 1'b1;
            end
        end
        if (i_flush) begin
            state_next = UNARMED;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= UNARMED;
            expected_reg <= '0;
        end else begin
            state_reg    <= state_next;
            expected_reg <= expected_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            seq_err_reg    <= 1'b0;
            err_count_reg  <= '0;
            sum_reg        <= '0;
        end else begin
            data_valid_reg <= pop;
            seq_err_reg    <= mismatch;
            if (pop) begin
                data_reg <= pop_word;
                sum_reg  <= sum_reg + 32'(pop_word);
            end
            if (mismatch && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    assign o_stall      = full;
    assign o_data       = data_reg;
    assign o_data_valid = data_valid_reg;
    assign o_seq_err    = seq_err_reg;
    assign o_err_count  = err_count_reg;
    assign o_sum        = sum_reg;

endmodule

// File: doc/stage_sink.md
STAGE_SINK -- requirements
Module: stage_sink

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DW, default 16, data width.
REQ-003 SHALL have ports:
- i_clk  input  1  single clock; all state updates on its rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream data valid.
- i_data  input  DW  upstream data.
- o_stall  output  1  stall to upstream (!ready).
- i_internal_stall  input  1  local drain hold, driven by the bench.
- i_flush  input  1  synchronous flush.
- o_data  output  DW  last drained word.
- o_data_valid  output  1  one-cycle pulse per drained word.
- o_seq_err  output  1  one-cycle pulse on a sequence mismatch.
- o_err_count  output  8  saturating mismatch count.
- o_sum  output  32  wrapping sum of drained words.

Function
REQ-004 SHALL accept (push) a word in any cycle with i_valid=1 and o_stall=0 and i_flush=0.
REQ-005 SHALL drive o_stall = (occupancy == DEPTH), decoded from registered occupancy only, with no combinational path from i_valid or i_internal_stall.
REQ-006 SHALL drop no accepted word and duplicate none; while full, a push is refused even if a pop occurs in the same cycle.
REQ-007 SHALL store words in FIFO order: circular read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter 0..DEPTH.
REQ-008 SHALL pop one word per cycle when occupancy > 0, i_internal_stall=0 and i_flush=0.
REQ-009 On a pop, SHALL register the popped word into o_data and assert o_data_valid for exactly the following cycle; o_data holds its value otherwise.
- Latency: a word pushed into an empty FIFO in cycle N appears on o_data with o_data_valid=1 in cycle N+2 if not held.
REQ-010 SHALL handle a simultaneous push and pop with occupancy unchanged and both pointers advanced.
REQ-011 SHALL run a two-state checker FSM: UNARMED, TRACK.
- UNARMED + pop: load expected = popped+1 (mod 2^DW); go to TRACK; no error.
- TRACK + pop, popped == expected: expected <= popped+1.
- TRACK + pop, popped != expected: pulse o_seq_err next cycle (aligned with o_data_valid); increment o_err_count, saturating at 255; resync expected <= popped+1; stay in TRACK.
REQ-012 SHALL add each popped word, zero-extended, to o_sum modulo 2^32.
REQ-013 i_flush=1 SHALL in the same edge:
- empty the FIFO (pointers and occupancy to 0);
- clear o_data_valid and o_seq_err;
- return the checker to UNARMED.
- Any push or pop in that cycle is discarded.
- o_sum, o_err_count and o_data are preserved.
REQ-014 SHALL keep o_data_valid, o_seq_err, o_sum and o_err_count unchanged while i_internal_stall=1 holds the FIFO.

Reset
REQ-015 i_rst=1 SHALL immediately, without waiting for a clock edge, force:
- occupancy, pointers, o_data, o_sum, o_err_count = 0;
- o_data_valid, o_seq_err = 0;
- o_stall = 0;
- checker = UNARMED.
REQ-016 Reset asserted mid-transfer SHALL discard FIFO contents; the first pop after release SHALL behave as UNARMED.
REQ-017 FIFO storage SHALL need no reset; no output may depend on unwritten entries.

Verification
REQ-018 SHALL cover these directed scenarios (DEPTH=4):
- Continuous stream 0,1,2,...,9 with no internal stall -> o_data shows 0..9 in order, 2-cycle latency, o_seq_err never set, o_sum=45, o_stall never set.
- i_internal_stall=1 while streaming 10,11,12,13,14 -> o_stall=1 once four words are held, 14 held upstream; on release o_data shows 10..14 in order, with no loss or duplicate.
- Stream 5,6,8,9 -> a single o_seq_err pulse aligned with o_data=8; o_err_count=1; 9 accepted as in-sequence.
- Full FIFO with push offered and pop in the same cycle -> push refused, occupancy drops to 3; the word is accepted on the next cycle.
- Flush with 3 entries held, then push 100,101 -> the old entries never appear; 100 pops with no error (UNARMED); o_sum continues from its prior value.
- Assert i_rst between clock edges while 2 entries are held -> all outputs read 0 before the next edge; the first word after release produces no o_seq_err.
- 300 deliberate mismatches -> o_err_count saturates at 255; 0xFFFF followed by 0x0000 counts as in-sequence (wrap).
